muldiv: RTL and testbench

- Iterative multiply/divide unit for the 64-bit integer pipeline.
- Executes MULT/MULTU/DIV/DIVU and DMULT/DMULTU/DDIV/DDIVU, and owns the HI/LO register pair.
- The EX stage is single-cycle. It launches an operation here with a start pulse and stalls on busy when a later MFHI/MFLO or a new start needs the unit.
- MTHI/MTLO write HI/LO directly.

---
 rtl/muldiv_if.sv | 20 ++
 rtl/muldiv.sv | 148 ++++++++++++++
 tb/tb_muldiv.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit: launch/kill controls, MTHI/MTLO writes, HI/LO and status back.
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        kill;
  logic        wrhi;
  logic        wrlo;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic [63:0] hi;
  logic [63:0] lo;

  modport master (output start, op, a, b, kill, wrhi, wrlo, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, kill, wrhi, wrlo, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv.sv
// Iterative 32/64-bit mul/div owning HI/LO; radix-2 shift-add / restoring divide, MULDIV_RADIX4_EN makes multiply radix-4.
// Latency N+1 clocks start->done (N = 32/64, multiply 16/32 with radix-4); EX stalls on busy, start while busy is dropped.
module muldiv (
  input  logic     clk,
  input  logic     rstn,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t       state;
  logic [6:0]   cnt;
  logic [127:0] acc;
  logic [63:0]  opnd;
  logic         is_div, dw, neg_lo, neg_hi;
  logic [63:0]  hi_q, lo_q;
  logic         busy_q, done_q;

  logic [63:0]  a_ext, b_ext, a_mag, b_mag;
  logic         a_neg, b_neg;
  logic [6:0]   n_start;

  // 32-bit operands are extended first, so bit 63 is the sign in both widths
  always_comb begin
    a_ext = bus.op[2] ? bus.a : (bus.op[0] ? {32'b0, bus.a[31:0]} : {{32{bus.a[31]}}, bus.a[31:0]});
    b_ext = bus.op[2] ? bus.b : (bus.op[0] ? {32'b0, bus.b[31:0]} : {{32{bus.b[31]}}, bus.b[31:0]});
    a_neg = !bus.op[0] && a_ext[63];
    b_neg = !bus.op[0] && b_ext[63];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
`ifdef MULDIV_RADIX4_EN
    if (bus.op[1]) n_start = bus.op[2] ? 7'd64 : 7'd32;
    else           n_start = bus.op[2] ? 7'd32 : 7'd16;
`else
    n_start = bus.op[2] ? 7'd64 : 7'd32;
`endif
  end

  logic [127:0] acc_mul, acc_div;
  logic [64:0]  rem_sh;
  logic [63:0]  rem_diff;
  logic         rem_ge;
`ifdef MULDIV_RADIX4_EN
  logic [65:0]  pp, mul_sum;
  always_comb begin
    pp      = ({2'b0, opnd} & {66{acc[0]}}) + ({1'b0, opnd, 1'b0} & {66{acc[1]}});
    mul_sum = {2'b0, acc[127:64]} + pp;
    acc_mul = {mul_sum, acc[63:2]};
  end
`else
  logic [64:0]  mul_sum;
  always_comb begin
    mul_sum = {1'b0, acc[127:64]} + ({1'b0, opnd} & {65{acc[0]}});
    acc_mul = {mul_sum, acc[63:1]};
  end
`endif

  // Restoring step: remainder in acc[127:64], dividend/quotient shifting through acc[63:0]
  always_comb begin
    rem_sh   = {acc[127:64], acc[63]};
    rem_ge   = rem_sh >= {1'b0, opnd};
    rem_diff = rem_sh[63:0] - opnd;
    acc_div  = {rem_ge ? rem_diff : rem_sh[63:0], acc[62:0], rem_ge};
  end

  // 32-bit products end up in acc[95:32] after 32 bit-positions of shifting
  logic [127:0] prod_mag, prod;
  logic [63:0]  quo, rmd, res_hi, res_lo;
  always_comb begin
    prod_mag = dw ? acc : {64'b0, acc[95:32]};
    prod     = neg_lo ? -prod_mag : prod_mag;
    quo      = neg_lo ? -acc[63:0] : acc[63:0];
    rmd      = neg_hi ? -acc[127:64] : acc[127:64];
    if (is_div) begin
      res_hi = dw ? rmd : {{32{rmd[31]}}, rmd[31:0]};
      res_lo = dw ? quo : {{32{quo[31]}}, quo[31:0]};
    end else begin
      res_hi = dw ? prod[127:64] : {{32{prod[63]}}, prod[63:32]};
      res_lo = dw ? prod[63:0]   : {{32{prod[31]}}, prod[31:0]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 7'd0;
      acc    <= 128'd0;
      opnd   <= 64'd0;
      is_div <= 1'b0;
      dw     <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= 64'd0;
      lo_q   <= 64'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wrhi) hi_q <= bus.wdata;
          if (bus.wrlo) lo_q <= bus.wdata;
          if (bus.start && !bus.kill) begin
            is_div <= bus.op[1];
            dw     <= bus.op[2];
            cnt    <= n_start;
            busy_q <= 1'b1;
            state  <= RUN;
            neg_lo <= a_neg ^ b_neg;
            if (bus.op[1]) begin
              opnd   <= b_mag;
              acc    <= {64'b0, bus.op[2] ? a_mag : {a_mag[31:0], 32'b0}};
              neg_hi <= a_neg;
            end else begin
              opnd   <= a_mag;
              acc    <= {64'b0, b_mag};
              neg_hi <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.kill) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= is_div ? acc_div : acc_mul;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (!bus.kill) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Scoreboarded bench for muldiv: directed corner cases plus random ops against an arithmetic reference model.
module tb_muldiv;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  muldiv_if bus();
  muldiv dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          lat;
    int          t0;
    logic [2:0]  op;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain arithmetic on the architectural operand values
  function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] h, output logic [63:0] l);
    logic [127:0] p128;
    logic [63:0]  p64, ea, eb;
    logic [31:0]  ua, ub;
    int           sa, sb;
    longint       la, lb;
    if (!op[1]) begin
      if (op[2]) begin
        ea = op[0] ? 64'd0 : {64{a[63]}};
        eb = op[0] ? 64'd0 : {64{b[63]}};
        p128 = {ea, a} * {eb, b};
        h = p128[127:64];
        l = p128[63:0];
      end else begin
        ea = op[0] ? {32'd0, a[31:0]} : sx32(a[31:0]);
        eb = op[0] ? {32'd0, b[31:0]} : sx32(b[31:0]);
        p64 = ea * eb;
        h = sx32(p64[63:32]);
        l = sx32(p64[31:0]);
      end
    end else if (!op[2]) begin
      ua = a[31:0];
      ub = b[31:0];
      sa = a[31:0];
      sb = b[31:0];
      if (ub == 32'd0) begin
        h = sx32(ua);
        l = (!op[0] && sa < 0) ? 64'd1 : {64{1'b1}};
      end else if (op[0]) begin
        l = sx32(ua / ub);
        h = sx32(ua % ub);
      end else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
        l = sx32(32'h8000_0000);
        h = 64'd0;
      end else begin
        l = sx32(32'(sa / sb));
        h = sx32(32'(sa % sb));
      end
    end else begin
      la = a;
      lb = b;
      if (b == 64'd0) begin
        h = a;
        l = (!op[0] && la < 0) ? 64'd1 : {64{1'b1}};
      end else if (op[0]) begin
        l = a / b;
        h = a % b;
      end else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
        l = a;
        h = 64'd0;
      end else begin
        l = la / lb;
        h = la % lb;
      end
    end
  endfunction

  function automatic int lat_of(input logic [2:0] op);
`ifdef MULDIV_RADIX4_EN
    if (!op[1]) return op[2] ? 33 : 17;
`endif
    return op[2] ? 65 : 33;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn === 1'b1 && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: actual done=1 required no pending op");
      end else begin
        e = sbq.pop_front();
        check($sformatf("hi op=%0d", e.op), bus.hi, e.hi);
        check($sformatf("lo op=%0d", e.op), bus.lo, e.lo);
        check($sformatf("latency op=%0d", e.op), 64'(cyc - e.t0), 64'(e.lat));
        check("busy_in_done_cycle", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  task automatic idle_wait();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: actual busy=%b required 0 within 300 cycles", bus.busy);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    idle_wait();
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    model(op, a, b, e.hi, e.lo);
    e.lat = lat_of(op);
    e.t0 = cyc + 1;
    e.op = op;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: actual %0d ops pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [63:0] ra, rb;
    int          sel;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 64'd0; bus.b = 64'd0;
    bus.kill = 1'b0; bus.wrhi = 1'b0; bus.wrlo = 1'b0; bus.wdata = 64'd0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hi", bus.hi, 64'd0);
    check("reset_lo", bus.lo, 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    issue(3'b000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    drain();
    issue(3'b101, {64{1'b1}}, {64{1'b1}});
    drain();
    issue(3'b010, -64'sd7, 64'd2);
    issue(3'b111, 64'd100, 64'd0);
    issue(3'b010, 64'h0000_0000_8000_0000, {64{1'b1}});
    issue(3'b010, -64'sd5, 64'd0);
    issue(3'b110, 64'h8000_0000_0000_0000, {64{1'b1}});
    issue(3'b011, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000);
    drain();

    // start during busy must not disturb the running op
    issue(3'b100, 64'h0123_4567_89AB_CDEF, -64'sd12345);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 64'd9; bus.b = 64'd2;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    @(negedge clk);
    bus.wrhi = 1'b1; bus.wdata = 64'h1234;
    @(negedge clk);
    bus.wrhi = 1'b0; bus.wrlo = 1'b1; bus.wdata = 64'h5678;
    @(negedge clk);
    bus.wrlo = 1'b0;
    check("mthi", bus.hi, 64'h1234);
    check("mtlo", bus.lo, 64'h5678);
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 64'd1000; bus.b = 64'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.wrhi = 1'b1; bus.wdata = 64'hDEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.wrhi = 1'b0;
    repeat (3) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy", {63'd0, bus.busy}, 64'd0);
    check("kill_hi", bus.hi, 64'h1234);
    check("kill_lo", bus.lo, 64'h5678);
    repeat (80) @(negedge clk);
    check("kill_hi_later", bus.hi, 64'h1234);

    bus.kill = 1'b1; bus.start = 1'b1; bus.op = 3'b001;
    @(negedge clk);
    bus.kill = 1'b0; bus.start = 1'b0;
    check("kill_start_idle_busy", {63'd0, bus.busy}, 64'd0);

    // MTLO on the start edge lands, then the result overwrites it
    bus.wrlo = 1'b1; bus.wdata = 64'hABCD;
    issue(3'b001, 64'd11, 64'd13);
    bus.wrlo = 1'b0;
    check("mtlo_with_start", bus.lo, 64'hABCD);
    drain();

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 64'd0;
      else if (sel == 1) begin
        ra = rop[2] ? 64'h8000_0000_0000_0000 : {ra[63:32], 32'h8000_0000};
        rb = {64{1'b1}};
      end else if (sel == 2) begin
        ra = {{48{ra[63]}}, ra[15:0]};
        rb = {{56{rb[63]}}, rb[7:0]};
      end
      issue(rop, ra, rb);
    end
    drain();

    issue(3'b100, 64'hFFFF_0000_1111_2222, 64'h7777_8888_9999_AAAA);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("async_rst_done", {63'd0, bus.done}, 64'd0);
    check("async_rst_hi", bus.hi, 64'd0);
    check("async_rst_lo", bus.lo, 64'd0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(3'b001, 64'd7, 64'd6);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
